// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the LCD reading formatter: FSM states, label
// bytes, frame geometry and the character helpers used to build each write.
package lcd_fmt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CONVERT   = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5
   } fmt_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic [7:0] LABEL_A     = 8'h41;
   localparam logic [7:0] LABEL_Q     = 8'h51;
   localparam logic [7:0] LABEL_I     = 8'h49;
   localparam logic [7:0] LABEL_COLON = 8'h3A;
   localparam logic [7:0] LABEL_SP    = 8'h20;

   localparam int LABEL_LEN  = 5;
   localparam int NUM_DIGITS = 5;
   localparam int FRAME_LEN  = 11;

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   function automatic logic [7:0] label_char(input logic [2:0] pos);
      logic [7:0] ch;
      case (pos)
         3'd0:    ch = LABEL_A;
         3'd1:    ch = LABEL_Q;
         3'd2:    ch = LABEL_I;
         3'd3:    ch = LABEL_COLON;
         3'd4:    ch = LABEL_SP;
         default: ch = ASCII_SPACE;
      endcase
      return ch;
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] digit, input logic blank);
      logic [7:0] ch;
      if (blank) begin
         ch = ASCII_SPACE;
      end else begin
         ch = ASCII_ZERO + {4'h0, digit};
      end
      return ch;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one shift per
// cycle; done pulses for one cycle the cycle after the 16th shift.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] shift_r;
   logic [19:0] bcd_r;
   logic [4:0]  cnt_r;
   logic        busy_r;
   logic        done_r;

   // Add-3 correction on every digit >= 5, then shift in the next binary bit.
   function automatic logic [19:0] dabble_step(input logic [19:0] b, input logic in_bit);
      logic [19:0] adj;
      adj = b;
      for (int i = 0; i < 5; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = b[4*i +: 4];
         end
      end
      return {adj[18:0], in_bit};
   endfunction

   // Load on start, shift while busy, raise done once the shifts are spent.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r <= 16'h0000;
         bcd_r   <= 20'h00000;
         cnt_r   <= 5'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            shift_r <= bin;
            bcd_r   <= 20'h00000;
            cnt_r   <= 5'd16;
            busy_r  <= 1'b1;
         end else if (busy_r) begin
            if (cnt_r != 5'd0) begin
               bcd_r   <= dabble_step(bcd_r, shift_r[15]);
               shift_r <= {shift_r[14:0], 1'b0};
               cnt_r   <= cnt_r - 5'd1;
            end else begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign done = done_r;
   assign bcd  = bcd_r;

endmodule

// File: rtl/lcd_reading_formatter.sv
// Paints one LCD row as "AQI: ddddd" through the 4-bit HD44780 write driver.
// Define LCD_FMT_LEADING_BLANK_EN to show leading zeros of d4..d1 as spaces.
module lcd_reading_formatter
   import lcd_fmt_pkg::*;
#(
   parameter int         GAP_CYCLES = 600,
   parameter logic [7:0] ROW_CMD    = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        value_valid,
   input  logic        lcd_busy,
   output logic        lcd_start,
   output logic        lcd_rs,
   output logic [7:0]  lcd_data,
   output logic        frame_busy
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam int BCD_W = 4 * NUM_DIGITS;

   fmt_state_t       state_r;
   logic             pend_r;
   logic [15:0]      pend_val_r;
   logic [BCD_W-1:0] digits_r;
   logic [3:0]       idx_r;
   logic [GAP_W-1:0] gap_r;

   logic             frame_end_s;
   logic             bcd_start_s;
   logic [15:0]      bcd_bin_s;
   logic             bcd_done_s;
   logic [BCD_W-1:0] bcd_s;
   logic [4:0]       blank_s;
   logic [2:0]       digit_pos_s;
   logic [7:0]       char_s;
   logic             rs_s;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (bcd_start_s),
      .bin   (bcd_bin_s),
      .done  (bcd_done_s),
      .bcd   (bcd_s)
   );

   // Last cycle of the final write's gap.
   always_comb begin
      frame_end_s = 1'b0;
      if ((state_r == ST_GAP) && (gap_r == {GAP_W{1'b0}}) && (idx_r == LAST_IDX)) begin
         frame_end_s = 1'b1;
      end else begin
         frame_end_s = 1'b0;
      end
   end

   // Kick the converter directly so a fresh reading starts converting this cycle.
   always_comb begin
      bcd_start_s = 1'b0;
      bcd_bin_s   = value;
      if ((state_r == ST_IDLE) && value_valid) begin
         bcd_start_s = 1'b1;
         bcd_bin_s   = value;
      end else if (frame_end_s && pend_r) begin
         bcd_start_s = 1'b1;
         bcd_bin_s   = pend_val_r;
      end else if (frame_end_s && value_valid) begin
         bcd_start_s = 1'b1;
         bcd_bin_s   = value;
      end else begin
         bcd_start_s = 1'b0;
         bcd_bin_s   = value;
      end
   end

   // Leading-zero suppression flags, most significant digit first; d0 never blanks.
   always_comb begin
      blank_s = 5'b00000;
`ifdef LCD_FMT_LEADING_BLANK_EN
      blank_s[4] = (digits_r[19:16] == 4'd0);
      blank_s[3] = blank_s[4] && (digits_r[15:12] == 4'd0);
      blank_s[2] = blank_s[3] && (digits_r[11:8] == 4'd0);
      blank_s[1] = blank_s[2] && (digits_r[7:4] == 4'd0);
      blank_s[0] = 1'b0;
`else
      blank_s = 5'b00000;
`endif
   end

   // Byte and register-select for the current write index.
   always_comb begin
      rs_s        = 1'b0;
      char_s      = 8'h00;
      digit_pos_s = 3'(LAST_IDX - idx_r);
      if (idx_r == 4'd0) begin
         rs_s   = 1'b0;
         char_s = ROW_CMD;
      end else if (idx_r <= 4'(LABEL_LEN)) begin
         rs_s   = 1'b1;
         char_s = label_char(3'(idx_r - 4'd1));
      end else if (idx_r <= LAST_IDX) begin
         rs_s   = 1'b1;
         char_s = digit_char(digits_r[{digit_pos_s, 2'b00} +: 4], blank_s[digit_pos_s]);
      end else begin
         rs_s   = 1'b0;
         char_s = 8'h00;
      end
   end

   // Frame sequencer, registered driver handshake and pending-reading slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         lcd_start  <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         frame_busy <= 1'b0;
         pend_r     <= 1'b0;
         pend_val_r <= 16'h0000;
         digits_r   <= {BCD_W{1'b0}};
         idx_r      <= 4'd0;
         gap_r      <= {GAP_W{1'b0}};
      end else begin
         lcd_start <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (value_valid) begin
                  frame_busy <= 1'b1;
                  state_r    <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               if (bcd_done_s) begin
                  digits_r <= bcd_s;
                  idx_r    <= 4'd0;
                  state_r  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!lcd_busy) begin
                  lcd_start <= 1'b1;
                  lcd_rs    <= rs_s;
                  lcd_data  <= char_s;
                  state_r   <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (lcd_busy) begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!lcd_busy) begin
                  gap_r   <= GAP_LOAD;
                  state_r <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_r != {GAP_W{1'b0}}) begin
                  gap_r <= gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
               end else if (idx_r != LAST_IDX) begin
                  idx_r   <= idx_r + 4'd1;
                  state_r <= ST_SEND;
               end else if (bcd_start_s) begin
                  state_r <= ST_CONVERT;
               end else begin
                  frame_busy <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         // A reading consumed at frame end frees the slot unless a newer one lands now.
         if (value_valid && (state_r != ST_IDLE) && !(frame_end_s && !pend_r)) begin
            pend_r     <= 1'b1;
            pend_val_r <= value;
         end else if (frame_end_s) begin
            pend_r <= 1'b0;
         end
      end
   end

endmodule
